// File: rtl/integrator_controller.sv
// integrator_controller
// Sequences one integration pass per tick: walks every neuron and, for each
// neuron, every axon. It issues read addresses to the synapse and spike
// memories and aligns the integrator strobes with the data that returns one
// cycle later. Each finished neuron index is handed to the leak/threshold
// stage over a valid/ready handshake.
module integrator_controller #(
  parameter int NUM_AXONS         = 256,
  parameter int NUM_NEURONS       = 256,
  parameter int AXON_ADDR_WIDTH   = 8,
  parameter int NEURON_ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         spike_in,
  input  logic                         synapse_in,
  output logic [AXON_ADDR_WIDTH-1:0]   axon_addr,
  output logic [NEURON_ADDR_WIDTH-1:0] neuron_addr,
  output logic                         next_neuron,
  output logic                         integrator_reg_en,
  output logic                         weight_en,
  output logic                         out_valid,
  output logic [NEURON_ADDR_WIDTH-1:0] out_neuron,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         tick_overrun
);

  localparam logic [AXON_ADDR_WIDTH-1:0]   LAST_AXON   = AXON_ADDR_WIDTH'(NUM_AXONS - 1);
  localparam logic [NEURON_ADDR_WIDTH-1:0] LAST_NEURON = NEURON_ADDR_WIDTH'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

  state_e                         state_q, state_d;
  logic [AXON_ADDR_WIDTH-1:0]     axon_q, axon_d;
  logic [NEURON_ADDR_WIDTH-1:0]   neuron_q, neuron_d;
  logic                           overrun_q, overrun_d;
  logic                           done_q, done_d;
  logic                           busy_q;
  logic                           out_valid_q;
  logic [AXON_ADDR_WIDTH-1:0]     axon_addr_q;
  logic                           exec_valid_q;
  logic                           exec_first_q;
  logic                           tick_accept;
  logic                           hit;

  // A tick is taken only from a settled IDLE; the done cycle still belongs
  // to the finishing pass, so a tick landing on it is dropped.
  assign tick_accept = tick & (state_q == ST_IDLE) & ~done_q;

  // Next-state logic for the pass sequencer and its counters.
  always_comb begin
    state_d   = state_q;
    axon_d    = axon_q;
    neuron_d  = neuron_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    if (tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick_accept) begin
          state_d   = ST_RUN;
          axon_d    = '0;
          neuron_d  = '0;
          overrun_d = 1'b0;
        end
      end
      ST_RUN: begin
        // The axon counter parks on the last axon rather than wrapping.
        if (axon_q == LAST_AXON) begin
          state_d = ST_DRAIN;
        end else begin
          axon_d = axon_q + AXON_ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        // One cycle for the execute stage to absorb the last axon's data.
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          if (neuron_q == LAST_NEURON) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_RUN;
            neuron_d = neuron_q + NEURON_ADDR_WIDTH'(1);
            axon_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      axon_q      <= '0;
      neuron_q    <= '0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      axon_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      axon_q      <= axon_d;
      neuron_q    <= neuron_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      busy_q      <= (state_d != ST_IDLE);
      out_valid_q <= (state_d == ST_OUTPUT);
      // Address bus is driven only while axons are actually being read.
      axon_addr_q <= (state_d == ST_RUN) ? axon_d : '0;
    end
  end

  // Execute stage: delays RUN and first-axon markers by the memory latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exec_valid_q <= 1'b0;
      exec_first_q <= 1'b0;
    end else begin
      exec_valid_q <= (state_q == ST_RUN);
      exec_first_q <= (axon_q == '0);
    end
  end

  // Spike and synapse bits arrive aligned with the execute stage.
  assign hit = spike_in & synapse_in;

  assign next_neuron       = exec_valid_q & exec_first_q;
  assign weight_en         = exec_valid_q & hit;
  assign integrator_reg_en = exec_valid_q & (exec_first_q | hit);

  assign axon_addr    = axon_addr_q;
  assign neuron_addr  = neuron_q;
  assign out_neuron   = neuron_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_integrator_controller.sv
// Directed bench for integrator_controller with 4 axons and 2 neurons.
module tb_integrator_controller;

  localparam int NA = 4;
  localparam int NN = 2;
  localparam int AW = 2;
  localparam int NW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          spike_in;
  logic          synapse_in;
  logic          out_ready;
  logic [AW-1:0] axon_addr;
  logic [NW-1:0] neuron_addr;
  logic [NW-1:0] out_neuron;
  logic          next_neuron;
  logic          integrator_reg_en;
  logic          weight_en;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic          tick_overrun;

  logic [NA-1:0] syn_mask;
  logic          spk;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  integrator_controller #(
    .NUM_AXONS        (NA),
    .NUM_NEURONS      (NN),
    .AXON_ADDR_WIDTH  (AW),
    .NEURON_ADDR_WIDTH(NW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tick             (tick),
    .spike_in         (spike_in),
    .synapse_in       (synapse_in),
    .axon_addr        (axon_addr),
    .neuron_addr      (neuron_addr),
    .next_neuron      (next_neuron),
    .integrator_reg_en(integrator_reg_en),
    .weight_en        (weight_en),
    .out_valid        (out_valid),
    .out_neuron       (out_neuron),
    .out_ready        (out_ready),
    .busy             (busy),
    .done             (done),
    .tick_overrun     (tick_overrun)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: memory returns data for the address seen before the edge.
  task automatic cyc();
    logic [AW-1:0] prev;
    prev = axon_addr;
    @(posedge clk);
    #1;
    synapse_in = syn_mask[prev];
    spike_in   = spk;
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      cyc();
      i++;
    end
    check(tag, int'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nn, ire, we, dn, dcyc, ov0, ov1;

    rst        = 1'b0;
    tick       = 1'b0;
    spike_in   = 1'b0;
    synapse_in = 1'b0;
    out_ready  = 1'b1;
    spk        = 1'b1;
    syn_mask   = '1;

    // Reset then idle
    repeat (3) cyc();
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    repeat (3) cyc();
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(out_valid), 0);
    check("idle_done", int'(done), 0);
    check("idle_nn", int'(next_neuron), 0);
    check("idle_ire", int'(integrator_reg_en), 0);
    check("idle_we", int'(weight_en), 0);
    check("idle_ovr", int'(tick_overrun), 0);
    check("idle_axon", int'(axon_addr), 0);

    // Full pass, everything connected
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    nn = 0; ire = 0; we = 0; dn = 0; dcyc = -1; ov0 = -1; ov1 = -1;
    for (int k = 0; k < 14; k++) begin
      if (k < 4) begin
        check("s2_axon_n0", int'(axon_addr), k);
        check("s2_neur_n0", int'(neuron_addr), 0);
      end
      if (k >= 6 && k < 10) begin
        check("s2_axon_n1", int'(axon_addr), k - 6);
        check("s2_neur_n1", int'(neuron_addr), 1);
      end
      nn  += int'(next_neuron);
      ire += int'(integrator_reg_en);
      we  += int'(weight_en);
      if (done) begin
        dn++;
        dcyc = k;
      end
      if (out_valid && out_neuron == 1'b0 && ov0 < 0) ov0 = k;
      if (out_valid && out_neuron == 1'b1 && ov1 < 0) ov1 = k;
      if (k < 13) cyc();
    end
    check("s2_next_neuron_cnt", nn, 2);
    check("s2_ire_cnt", ire, 8);
    check("s2_we_cnt", we, 8);
    check("s2_done_cnt", dn, 1);
    check("s2_done_cycle", dcyc, 12);
    check("s2_valid_n0_cycle", ov0, 5);
    check("s2_valid_n1_cycle", ov1, 11);
    check("s2_end_busy", int'(busy), 0);

    // Sparse synapses: only axon 2 connected
    syn_mask = 4'b0100;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    for (int a = 0; a < 4; a++) begin
      check("s3_ire", int'(integrator_reg_en), (a == 0 || a == 2) ? 1 : 0);
      check("s3_we", int'(weight_en), (a == 2) ? 1 : 0);
      check("s3_nn", int'(next_neuron), (a == 0) ? 1 : 0);
      cyc();
    end
    wait_done("s3_done", 20);
    cyc();
    syn_mask = '1;

    // Back-pressure on neuron 0
    out_ready = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (5) cyc();
    for (int i = 0; i < 5; i++) begin
      check("s4_hold_valid", int'(out_valid), 1);
      check("s4_hold_neuron", int'(out_neuron), 0);
      check("s4_hold_ire", int'(integrator_reg_en), 0);
      check("s4_hold_axon", int'(axon_addr), 0);
      check("s4_hold_busy", int'(busy), 1);
      cyc();
    end
    out_ready = 1'b1;
    check("s4_valid_at_rise", int'(out_valid), 1);
    cyc();
    check("s4_n1_busy", int'(busy), 1);
    check("s4_n1_valid", int'(out_valid), 0);
    check("s4_n1_neuron", int'(neuron_addr), 1);
    check("s4_n1_axon", int'(axon_addr), 0);
    cyc();
    check("s4_n1_next_neuron", int'(next_neuron), 1);
    wait_done("s4_done", 20);
    cyc();

    // Overrun, and a tick on the done cycle
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("s5_ovr_set", int'(tick_overrun), 1);
    check("s5_no_restart", int'(axon_addr), 3);
    wait_done("s5_done", 20);
    check("s5_ovr_sticky", int'(tick_overrun), 1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("s5_done_tick_ignored", int'(busy), 0);
    check("s5_ovr_kept", int'(tick_overrun), 1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("s5_restart_busy", int'(busy), 1);
    check("s5_ovr_clear", int'(tick_overrun), 0);
    check("s5_restart_axon", int'(axon_addr), 0);

    // Reset in the middle of neuron 1
    repeat (7) cyc();
    check("s6_pre_neuron", int'(neuron_addr), 1);
    check("s6_pre_axon", int'(axon_addr), 1);
    rst = 1'b0;
    #1;
    check("s6_rst_busy", int'(busy), 0);
    check("s6_rst_axon", int'(axon_addr), 0);
    check("s6_rst_neuron", int'(neuron_addr), 0);
    check("s6_rst_nn", int'(next_neuron), 0);
    check("s6_rst_ire", int'(integrator_reg_en), 0);
    check("s6_rst_we", int'(weight_en), 0);
    check("s6_rst_valid", int'(out_valid), 0);
    cyc();
    cyc();
    rst = 1'b1;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      dn += int'(done);
      cyc();
    end
    check("s6_no_done", dn, 0);
    check("s6_idle_busy", int'(busy), 0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("s6_restart_busy", int'(busy), 1);
    check("s6_restart_axon", int'(axon_addr), 0);
    check("s6_restart_neuron", int'(neuron_addr), 0);
    cyc();
    check("s6_restart_nn", int'(next_neuron), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
